// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver FSM state type and default frame geometry.
package uart_pkg;
    localparam int DEFAULT_DATA_BITS  = 8;
    localparam int DEFAULT_OVERSAMPLE = 16;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer for one asynchronous bit.
// Ports: clk, rst (sync active-high, loads RST_VAL), d (async in), q (synchronized out).
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic r_meta;
    logic r_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RST_VAL;
            r_q    <= RST_VAL;
        end else begin
            r_meta <= d;
            r_q    <= r_meta;
        end
    end
    assign q = r_q;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with valid/ready output and error flags.
// Ports: clk, rst (sync active-high), oversample_tick (OVERSAMPLE x baud strobe),
//        rx_in (async line, idles high), rx_data/rx_valid/rx_ready (output handshake),
//        rx_busy (not IDLE), frame_error, overrun (sticky), parity_error (UART_RX_PARITY_EN).
// Build option: define UART_RX_PARITY_EN for an even parity bit after the data bits.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DEFAULT_DATA_BITS,
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 oversample_tick,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_busy,
    output logic                 frame_error,
    output logic                 overrun
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 parity_error
`endif
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_END  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
`ifdef UART_RX_PARITY_EN
    localparam rx_state_t AFTER_DATA = PARITY;
`else
    localparam rx_state_t AFTER_DATA = STOP;
`endif

    logic                 w_rxs;
    rx_state_t            r_state;
    rx_state_t            w_next;
    logic [TW-1:0]        r_tick;
    logic [BW-1:0]        r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_fe;
    logic                 r_ovr;
    logic                 r_pe;
    logic                 w_mid;
    logic                 w_end;
    logic                 w_done;

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (.clk(clk), .rst(rst), .d(rx_in), .q(w_rxs));

    assign w_mid  = oversample_tick && r_tick == T_MID;
    assign w_end  = oversample_tick && r_tick == T_END;
    assign w_done = r_state == STOP && w_end;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:   if (oversample_tick && !w_rxs) w_next = START;
            START:  if (w_mid) w_next = w_rxs ? IDLE : DATA;
            DATA:   if (w_end && r_bit == B_LAST) w_next = AFTER_DATA;
`ifdef UART_RX_PARITY_EN
            PARITY: if (w_end) w_next = STOP;
`endif
            STOP:   if (w_end) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        rx_busy = r_state != IDLE;
    end

    // Tick counter restarts at the start-bit midpoint so later samples land mid-bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
        end else if (oversample_tick) begin
            r_tick <= (r_state == IDLE || (r_state == START && r_tick == T_MID) || r_tick == T_END) ? '0 : r_tick + 1'b1;
            if (r_state == DATA && r_tick == T_END) begin
                r_shift[r_bit] <= w_rxs;
                r_bit          <= (r_bit == B_LAST) ? '0 : r_bit + 1'b1;
            end
            if (r_state == PARITY && r_tick == T_END) r_par <= w_rxs;
        end
    end

    // A word may load when the holding register is empty or being drained this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_fe    <= 1'b0;
            r_ovr   <= 1'b0;
            r_pe    <= 1'b0;
        end else if (w_done && (!r_valid || rx_ready)) begin
            r_data  <= r_shift;
            r_valid <= 1'b1;
            r_fe    <= !w_rxs;
            r_pe    <= ^{r_shift, r_par};
        end else begin
            r_ovr   <= r_ovr | w_done;
            r_valid <= r_valid & ~rx_ready;
        end
    end

    assign rx_data     = r_data;
    assign rx_valid    = r_valid;
    assign frame_error = r_fe;
    assign overrun     = r_ovr;
`ifdef UART_RX_PARITY_EN
    assign parity_error = r_pe;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against uart_rx with hand-computed expectations.
module tb_uart_rx;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       oversample_tick = 1'b0;
    logic       rx_in = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_error;
    logic       overrun;
`ifdef UART_RX_PARITY_EN
    logic       parity_error;
    logic       tx_par = 1'b0;
`endif
    int         n_cmp = 0;
    int         n_bad = 0;
    int         tick_cnt = 0;
    logic [7:0] acc_data = 8'h00;

    uart_rx dut (
        .clk(clk),
        .rst(rst),
        .oversample_tick(oversample_tick),
        .rx_in(rx_in),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .rx_busy(rx_busy),
        .frame_error(frame_error),
        .overrun(overrun)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_error(parity_error)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            oversample_tick = (tick_cnt == 2);
            tick_cnt = (tick_cnt + 1) % 3;
        end
    end

    always @(posedge clk) if (rx_valid && rx_ready) acc_data = rx_data;

    task chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task drive(input logic b, input int n);
        rx_in = b;
        repeat (n) @(negedge clk);
    endtask

    task send(input logic [7:0] d, input logic stop_ok);
        drive(1'b0, 48);
        for (int i = 0; i < 8; i++) drive(d[i], 48);
`ifdef UART_RX_PARITY_EN
        drive(tx_par, 48);
`endif
        if (stop_ok) drive(1'b1, 48);
        else begin
            drive(1'b0, 36);
            drive(1'b1, 12);
        end
    endtask

    task accept();
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_data", 32'(rx_data), 32'h00);
        chk("rst_valid", 32'(rx_valid), 32'h0);
        chk("rst_busy", 32'(rx_busy), 32'h0);
        chk("rst_fe", 32'(frame_error), 32'h0);
        chk("rst_ovr", 32'(overrun), 32'h0);
`ifdef UART_RX_PARITY_EN
        chk("rst_pe", 32'(parity_error), 32'h0);
`endif
        rst = 1'b0;
        drive(1'b1, 20);

        send(8'hA5, 1'b1);
        chk("a5_valid", 32'(rx_valid), 32'h1);
        chk("a5_data", 32'(rx_data), 32'hA5);
        chk("a5_fe", 32'(frame_error), 32'h0);
        chk("a5_busy", 32'(rx_busy), 32'h0);
        accept();
        chk("a5_cleared", 32'(rx_valid), 32'h0);
        chk("a5_accepted", 32'(acc_data), 32'hA5);

        drive(1'b0, 12);
        chk("glitch_busy", 32'(rx_busy), 32'h1);
        drive(1'b1, 48);
        chk("glitch_idle", 32'(rx_busy), 32'h0);
        chk("glitch_valid", 32'(rx_valid), 32'h0);

        send(8'h3C, 1'b0);
        drive(1'b1, 60);
        chk("3c_valid", 32'(rx_valid), 32'h1);
        chk("3c_data", 32'(rx_data), 32'h3C);
        chk("3c_fe", 32'(frame_error), 32'h1);
        chk("3c_idle", 32'(rx_busy), 32'h0);
        accept();
        send(8'h55, 1'b1);
        chk("55_data", 32'(rx_data), 32'h55);
        chk("55_fe", 32'(frame_error), 32'h0);
        accept();

        send(8'h11, 1'b1);
        chk("11_data", 32'(rx_data), 32'h11);
        chk("11_ovr", 32'(overrun), 32'h0);
        send(8'h22, 1'b1);
        chk("ovr_data", 32'(rx_data), 32'h11);
        chk("ovr_valid", 32'(rx_valid), 32'h1);
        chk("ovr_flag", 32'(overrun), 32'h1);
        rx_ready = 1'b1;
        send(8'h33, 1'b1);
        chk("33_accepted", 32'(acc_data), 32'h33);
        chk("33_valid", 32'(rx_valid), 32'h0);
        chk("ovr_sticky", 32'(overrun), 32'h1);
        rx_ready = 1'b0;

        drive(1'b0, 48);
        for (int i = 0; i < 4; i++) drive(1'b0, 48);
        drive(1'b0, 24);
        chk("mid_busy", 32'(rx_busy), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_busy", 32'(rx_busy), 32'h0);
        chk("mrst_valid", 32'(rx_valid), 32'h0);
        chk("mrst_data", 32'(rx_data), 32'h00);
        chk("mrst_ovr", 32'(overrun), 32'h0);
        chk("mrst_fe", 32'(frame_error), 32'h0);
        drive(1'b1, 60);
        send(8'h81, 1'b1);
        chk("81_valid", 32'(rx_valid), 32'h1);
        chk("81_data", 32'(rx_data), 32'h81);
        chk("81_fe", 32'(frame_error), 32'h0);
        chk("81_ovr", 32'(overrun), 32'h0);
        accept();

`ifdef UART_RX_PARITY_EN
        tx_par = 1'b1;
        send(8'h07, 1'b1);
        chk("par_ok_data", 32'(rx_data), 32'h07);
        chk("par_ok_pe", 32'(parity_error), 32'h0);
        accept();
        tx_par = 1'b0;
        send(8'h07, 1'b1);
        chk("par_bad_pe", 32'(parity_error), 32'h1);
        accept();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
